serial_frame_receiver: RTL

- Receive-side counterpart of the team's 19-bit serial link. Deserializes frames of 3-bit address + 16-bit data, sent MSB first, one bit per clock.
- Validates frame length against the last-bit marker and writes each good word into an 8-entry x 16-bit register file.
- Exposes the decoded word with a one-cycle valid strobe, a registered read port, and error/frame counters for status readback.

---
 rtl/serial_frame_receiver_pkg.sv | 20 ++
 rtl/serial_frame_receiver_if.sv | 35 +++
 rtl/serial_frame_receiver_regfile.sv | 37 +++
 rtl/serial_frame_receiver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// serial_frame_receiver_pkg
// Shared definitions for the 19-bit serial link (receive and transmit sides):
// field widths, frame length, counter widths and the framing state encoding.
package serial_frame_receiver_pkg;

  localparam int ADDR_W      = 3;
  localparam int DATA_W      = 16;
  localparam int FRAME_LEN   = ADDR_W + DATA_W;
  localparam int ERR_CNT_W   = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int BIT_CNT_W   = $clog2(FRAME_LEN + 1);
  localparam int RF_DEPTH    = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if
// Bundles the serial input, decoded-word output, read port and status signals
// of the frame receiver.
//   slave  : the receiver (consumes SER_IN/FRAME_EN/LAST_IN/RD_ADDR,
//            drives word, read data and status)
//   master : the link source / host side (the reverse directions)
interface serial_frame_receiver_if;
  import serial_frame_receiver_pkg::*;

  logic                   SER_IN;
  logic                   FRAME_EN;
  logic                   LAST_IN;
  logic [ADDR_W-1:0]      ADDR_OUT;
  logic [DATA_W-1:0]      DATA_OUT;
  logic                   WORD_VALID;
  logic [ADDR_W-1:0]      RD_ADDR;
  logic [DATA_W-1:0]      RD_DATA;
  logic                   LEN_ERR;
  logic [ERR_CNT_W-1:0]   ERR_CNT;
  logic [FRAME_CNT_W-1:0] FRAME_CNT;
  logic                   BUSY;

  modport slave (
    input  SER_IN, FRAME_EN, LAST_IN, RD_ADDR,
    output ADDR_OUT, DATA_OUT, WORD_VALID, RD_DATA, LEN_ERR, ERR_CNT,
           FRAME_CNT, BUSY
  );

  modport master (
    output SER_IN, FRAME_EN, LAST_IN, RD_ADDR,
    input  ADDR_OUT, DATA_OUT, WORD_VALID, RD_DATA, LEN_ERR, ERR_CNT,
           FRAME_CNT, BUSY
  );

endinterface

// File: rtl/serial_frame_receiver_regfile.sv
// frame_regfile
// RF_DEPTH x DATA_W storage written by good frames.
//   CLK, RST  : clock, asynchronous active-high reset (clears all entries)
//   WR_EN     : write strobe, WR_ADDR/WR_DATA written on the rising edge
//   RD_ADDR   : read address, RD_DATA registered one cycle later
// A same-cycle read and write of one address returns the old contents.
module frame_regfile
  import serial_frame_receiver_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA
);

  logic [DATA_W-1:0] mem [RF_DEPTH];

  // Storage and registered read port share one process so the read sees the
  // pre-write contents on a collision.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      RD_DATA <= '0;
    end else begin
      if (WR_EN) begin
        mem[WR_ADDR] <= WR_DATA;
      end
      RD_DATA <= mem[RD_ADDR];
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
// Deserializes 19-bit frames (3-bit address, 16-bit data, MSB first), checks
// the frame length against LAST_IN, and stores good words in frame_regfile.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : serial_frame_receiver_if.slave
//              in : SER_IN, FRAME_EN, LAST_IN, RD_ADDR
//              out: ADDR_OUT, DATA_OUT, WORD_VALID (1-cycle), RD_DATA,
//                   LEN_ERR (1-cycle), ERR_CNT (saturating),
//                   FRAME_CNT (wrapping), BUSY
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  serial_frame_receiver_if.slave bus
);

  frame_state_t           state, state_next;
  logic [FRAME_LEN-1:0]   shift_reg;
  logic [FRAME_LEN-1:0]   frame_next;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   last_slot;

  logic                   take_bit;
  logic                   first_bit;
  logic                   good_frame;
  logic                   len_err_det;

  logic [ADDR_W-1:0]      addr_out;
  logic [DATA_W-1:0]      data_out;
  logic                   word_valid;
  logic                   len_err;
  logic [ERR_CNT_W-1:0]   err_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [DATA_W-1:0]      rd_data;

  // Frame as it would look with the current bit appended; on the LAST_IN
  // cycle of a good frame this is the complete word, decoded on that edge.
  assign frame_next = (shift_reg << 1) | FRAME_LEN'(bus.SER_IN);
  assign last_slot  = (bit_cnt == BIT_CNT_W'(FRAME_LEN - 1));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Framing decisions. Returning to IDLE on LAST_IN lets the next frame start
  // in the following cycle with no bubble. LAST_IN without FRAME_EN is ignored.
  always_comb begin
    state_next  = state;
    take_bit    = 1'b0;
    first_bit   = 1'b0;
    good_frame  = 1'b0;
    len_err_det = 1'b0;
    case (state)
      IDLE: begin
        if (bus.FRAME_EN) begin
          if (bus.LAST_IN) begin
            len_err_det = 1'b1;
          end else begin
            take_bit   = 1'b1;
            first_bit  = 1'b1;
            state_next = RECV;
          end
        end
      end
      RECV: begin
        if (!bus.FRAME_EN) begin
          len_err_det = 1'b1;
          state_next  = IDLE;
        end else if (bus.LAST_IN) begin
          state_next = IDLE;
          if (last_slot) begin
            good_frame = 1'b1;
          end else begin
            len_err_det = 1'b1;
          end
        end else if (last_slot) begin
          len_err_det = 1'b1;
          state_next  = DRAIN;
        end else begin
          take_bit = 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.FRAME_EN) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register and bit counter; the first bit clears stale contents.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (take_bit) begin
      if (first_bit) begin
        shift_reg <= FRAME_LEN'(bus.SER_IN);
        bit_cnt   <= BIT_CNT_W'(1);
      end else begin
        shift_reg <= frame_next;
        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

  // Decoded word, strobes and counters. ERR_CNT sticks at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_out   <= '0;
      data_out   <= '0;
      word_valid <= 1'b0;
      len_err    <= 1'b0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      word_valid <= good_frame;
      len_err    <= len_err_det;
      if (good_frame) begin
        addr_out  <= frame_next[FRAME_LEN-1:DATA_W];
        data_out  <= frame_next[DATA_W-1:0];
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
      if (len_err_det && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  frame_regfile u_regfile (
    .CLK     (CLK),
    .RST     (RST),
    .WR_EN   (good_frame),
    .WR_ADDR (frame_next[FRAME_LEN-1:DATA_W]),
    .WR_DATA (frame_next[DATA_W-1:0]),
    .RD_ADDR (bus.RD_ADDR),
    .RD_DATA (rd_data)
  );

  assign bus.ADDR_OUT   = addr_out;
  assign bus.DATA_OUT   = data_out;
  assign bus.WORD_VALID = word_valid;
  assign bus.LEN_ERR    = len_err;
  assign bus.ERR_CNT    = err_cnt;
  assign bus.FRAME_CNT  = frame_cnt;
  assign bus.RD_DATA    = rd_data;
  assign bus.BUSY       = (state == RECV) || (state == DRAIN);

endmodule
